pipe_datapath_fwd: RTL and testbench
====================================

// Module: pipe_datapath_fwd
// PURPOSE
//  Parametrised 4-stage (ID/EX/MEM/WB) CPU datapath: regfile, sign-extend/const muxes, ALU,
//  data memory and stage registers, extended with a valid-tracked pipeline, EX-stage
//  forwarding, a write-through regfile bypass and a load-use stall with an in_valid/in_ready
//  handshake. Sits between the control decoder (drives fields and control) and the PC/branch logic (reads regRS, flags).
// PARAMETERS
//  WIDTH  32  datapath width; must be >= 16
//  NREGS  32  register count; REGW = $clog2(NREGS); reg 0 reads as 0
//  DEPTH  64  data memory words; MEMW = $clog2(DEPTH)
// PORTS
//  clk        in   1      single clock, all state on posedge
//  reset      in   1      asynchronous, active-low; clears all state
//  in_valid   in   1      instruction fields/controls below are valid
//  in_ready   out  1      0 = load-use stall, instruction not accepted
//  Rs,Rt,Rd   in   REGW   source/source/dest register addresses
//  imm16      in   16     immediate, sign-extended to WIDTH
//  ALUSource,RegWrite,MemWrite,MemToReg,RegDest,Branch  in 1 each  control bits
//  ALUControl in   2      00 add, 01 sub, 10 and, 11 or
//  regRS      out  WIDTH-2 combinational readRs[WIDTH-1:2] of current Rs (with WB bypass)
//  negative,zero,CarryOut,overflow  out 1 each  registered flags of last valid EX op
//  wb_valid   out  1      registered: a valid instruction is in WB this cycle
//  wb_addr    out  REGW   WB dest register; wb_data out WIDTH WB write value
// BEHAVIOUR
//  - Reset (reset=0): all stage valids, flags, wb_* = 0; regfile and memory cleared to 0;
//    in_ready=1. In-flight instructions discarded, no writes occur, incl. reset mid-operation.
//  - Accept: posedge with in_valid && in_ready captures operands/controls into ID/EX.
//    Not accepted -> bubble (valid=0) enters ID/EX. Bubbles never write regfile/memory/flags.
//  - Write address = RegDest ? Rd : Rt. Const = Branch ? 0 : signext(imm16).
//    ALU B = ALUSource ? const : rt_val.
//  - Timeline: accept edge E0 -> EX result captured E1 -> mem read/write at E1..E2
//    (store writes at E2) -> regfile write at E3 when RegWrite; wb_* describe it during E2..E3.
//  - Memory: async read, sync write; address = ALU result[MEMW-1:0] (upper bits ignored, wraps).
//    Store data = forwarded Rt value of that instruction.
//  - ID bypass: reading register written by WB in same cycle returns the new value.
//  - EX forwarding (Rs and Rt independently, never for reg 0, only from valid RegWrite stages):
//    priority EX/MEM ALU result, then MEM/WB write value, else ID/EX captured value.
//  - Load-use: ID/EX valid && MemToReg && RegWrite && dest!=0 && dest matches incoming Rs,
//    or matches Rt where Rt is read (ALUSource=0 or MemWrite=1) -> in_ready=0 for one cycle,
//    bubble inserted; next cycle forwarding from MEM/WB resolves it.
//  - ALU: add/sub give CarryOut (sub: carry = no borrow) and signed overflow; and/or force
//    CarryOut=overflow=0. zero = result==0, negative = result[WIDTH-1]. Flags hold on bubbles.
//  - Writes to reg 0 ignored. Result widths are WIDTH, modulo 2^WIDTH.
// TESTING
//  1 Reset then ADDI r1=r0+4 -> wb_valid, wb_addr=1, wb_data=4 3 edges after accept; regRS
//    for Rs=1 afterwards = 1 (4>>2).
//  2 Back-to-back ADDI r1=r0+4, ADDI r2=r1+3, ADDI r3=r2+1 (no gaps) -> wb_data 4,7,8
//    via EX/MEM and MEM/WB forwarding.
//  3 SW mem[r0+1]=r1 (r1=4) then LW r5=mem[r0+1] then ADD r6=r5+r5 -> in_ready low exactly
//    one cycle after LW accept; r6=8.
//  4 SUB 0x7FFFFFFF-(-1) -> overflow=1, negative=1; SUB 5-5 -> zero=1, CarryOut=1; AND
//    0xF0&0x0F -> zero=1, CarryOut=0.
//  5 ADDI r0=r0+9 then ADD r4=r0+r0 -> r4=0, no forwarding from r0.
//  6 Assert reset with 3 instructions in flight -> no regfile/memory change, wb_valid=0,
//    flags=0; fresh ADDI after release completes normally.

Source files
------------

// File: rtl/pipe_datapath_fwd_if.sv
// Decoder-facing bus of the forwarding datapath: instruction fields and controls in,
// handshake, branch operand, ALU flags and write-back observation out.
interface pipe_datapath_fwd_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
);
  localparam int REGW = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [REGW-1:0]  Rs;
  logic [REGW-1:0]  Rt;
  logic [REGW-1:0]  Rd;
  logic [15:0]      imm16;
  logic             ALUSource;
  logic             RegWrite;
  logic             MemWrite;
  logic             MemToReg;
  logic             RegDest;
  logic             Branch;
  logic [1:0]       ALUControl;
  logic [WIDTH-3:0] regRS;
  logic             negative;
  logic             zero;
  logic             CarryOut;
  logic             overflow;
  logic             wb_valid;
  logic [REGW-1:0]  wb_addr;
  logic [WIDTH-1:0] wb_data;

  modport master (
    output in_valid, Rs, Rt, Rd, imm16, ALUSource, RegWrite, MemWrite, MemToReg,
           RegDest, Branch, ALUControl,
    input  in_ready, regRS, negative, zero, CarryOut, overflow, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, Rs, Rt, Rd, imm16, ALUSource, RegWrite, MemWrite, MemToReg,
           RegDest, Branch, ALUControl,
    output in_ready, regRS, negative, zero, CarryOut, overflow, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/pipe_datapath_fwd.sv
// 4-stage ID/EX/MEM/WB datapath with regfile write-through bypass, EX forwarding
// and a one-cycle load-use stall exposed through in_valid/in_ready.
module pipe_datapath_fwd #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int DEPTH = 64
) (
  input logic                clk,
  input logic                reset,
  pipe_datapath_fwd_if.slave bus
);
  localparam int REGW = $clog2(NREGS);
  localparam int MEMW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] mem  [DEPTH];

  logic             idex_valid, idex_alusrc, idex_regw, idex_memw, idex_m2r;
  logic [REGW-1:0]  idex_rs, idex_rt, idex_dst;
  logic [WIDTH-1:0] idex_a, idex_b, idex_const;
  logic [1:0]       idex_op;

  logic             exmem_valid, exmem_regw, exmem_memw, exmem_m2r;
  logic [REGW-1:0]  exmem_dst;
  logic [WIDTH-1:0] exmem_alu, exmem_sd;

  logic             memwb_valid, memwb_regw;
  logic [REGW-1:0]  memwb_dst;
  logic [WIDTH-1:0] memwb_data;

  logic             flag_n, flag_z, flag_c, flag_v;

  logic             wb_we, exmem_fw, load_use, accept;
  logic [WIDTH-1:0] rs_val, rt_val, op_a, fwd_b, op_b, alu_r, mem_rd, mem_wdata;
  logic             alu_c, alu_v;

  assign wb_we    = memwb_valid && memwb_regw && (memwb_dst != '0);
  assign exmem_fw = exmem_valid && exmem_regw && (exmem_dst != '0);

  // ID read: the value being written back this cycle wins over the stored copy
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (bus.Rs != '0) rs_val = (wb_we && memwb_dst == bus.Rs) ? memwb_data : regs[bus.Rs];
    if (bus.Rt != '0) rt_val = (wb_we && memwb_dst == bus.Rt) ? memwb_data : regs[bus.Rt];
  end

  always_comb begin
    load_use = idex_valid && idex_m2r && idex_regw && (idex_dst != '0) &&
               ((idex_dst == bus.Rs) ||
                ((idex_dst == bus.Rt) && (!bus.ALUSource || bus.MemWrite)));
  end

  assign accept = bus.in_valid && !load_use;

  always_comb begin
    op_a = idex_a;
    if (idex_rs != '0) begin
      if (exmem_fw && exmem_dst == idex_rs)   op_a = exmem_alu;
      else if (wb_we && memwb_dst == idex_rs) op_a = memwb_data;
    end
    fwd_b = idex_b;
    if (idex_rt != '0) begin
      if (exmem_fw && exmem_dst == idex_rt)   fwd_b = exmem_alu;
      else if (wb_we && memwb_dst == idex_rt) fwd_b = memwb_data;
    end
  end

  assign op_b = idex_alusrc ? idex_const : fwd_b;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (idex_op)
      2'b00: begin
        {alu_c, alu_r} = {1'b0, op_a} + {1'b0, op_b};
        alu_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_r[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b01: begin
        {alu_c, alu_r} = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_r[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b10:   alu_r = op_a & op_b;
      default: alu_r = op_a | op_b;
    endcase
  end

  assign mem_rd    = mem[exmem_alu[MEMW-1:0]];
  assign mem_wdata = exmem_m2r ? mem_rd : exmem_alu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_valid  <= 1'b0;
      idex_alusrc <= 1'b0;
      idex_regw   <= 1'b0;
      idex_memw   <= 1'b0;
      idex_m2r    <= 1'b0;
      idex_rs     <= '0;
      idex_rt     <= '0;
      idex_dst    <= '0;
      idex_a      <= '0;
      idex_b      <= '0;
      idex_const  <= '0;
      idex_op     <= '0;
      exmem_valid <= 1'b0;
      exmem_regw  <= 1'b0;
      exmem_memw  <= 1'b0;
      exmem_m2r   <= 1'b0;
      exmem_dst   <= '0;
      exmem_alu   <= '0;
      exmem_sd    <= '0;
      memwb_valid <= 1'b0;
      memwb_regw  <= 1'b0;
      memwb_dst   <= '0;
      memwb_data  <= '0;
      flag_n      <= 1'b0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
    end else begin
      idex_valid <= accept;
      if (accept) begin
        idex_alusrc <= bus.ALUSource;
        idex_regw   <= bus.RegWrite;
        idex_memw   <= bus.MemWrite;
        idex_m2r    <= bus.MemToReg;
        idex_rs     <= bus.Rs;
        idex_rt     <= bus.Rt;
        idex_dst    <= bus.RegDest ? bus.Rd : bus.Rt;
        idex_a      <= rs_val;
        idex_b      <= rt_val;
        idex_const  <= bus.Branch ? '0 : {{(WIDTH-16){bus.imm16[15]}}, bus.imm16};
        idex_op     <= bus.ALUControl;
      end
      exmem_valid <= idex_valid;
      if (idex_valid) begin
        exmem_regw <= idex_regw;
        exmem_memw <= idex_memw;
        exmem_m2r  <= idex_m2r;
        exmem_dst  <= idex_dst;
        exmem_alu  <= alu_r;
        exmem_sd   <= fwd_b;
        flag_n     <= alu_r[WIDTH-1];
        flag_z     <= (alu_r == '0);
        flag_c     <= alu_c;
        flag_v     <= alu_v;
      end
      memwb_valid <= exmem_valid;
      if (exmem_valid) begin
        memwb_regw <= exmem_regw;
        memwb_dst  <= exmem_dst;
        memwb_data <= mem_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       mem <= '{default: '0};
    else if (exmem_valid && exmem_memw) mem[exmem_alu[MEMW-1:0]] <= exmem_sd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     regs <= '{default: '0};
    else if (wb_we) regs[memwb_dst] <= memwb_data;
  end

  assign bus.in_ready = !load_use;
  assign bus.regRS    = rs_val[WIDTH-1:2];
  assign bus.negative = flag_n;
  assign bus.zero     = flag_z;
  assign bus.CarryOut = flag_c;
  assign bus.overflow = flag_v;
  assign bus.wb_valid = memwb_valid;
  assign bus.wb_addr  = memwb_dst;
  assign bus.wb_data  = memwb_data;
endmodule

// File: tb/tb_pipe_datapath_fwd.sv
// Directed bench for pipe_datapath_fwd: forwarding, bypass, load-use stall, flags, reset.
module tb_pipe_datapath_fwd;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int DEPTH = 64;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_stalls = 0;

  always #5 clk = ~clk;

  pipe_datapath_fwd_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

  pipe_datapath_fwd #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] nzcv();
    return {28'b0, bus.negative, bus.zero, bus.CarryOut, bus.overflow};
  endfunction

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peek_rs(input logic [4:0] r);
    bus.Rs = r;
    #1;
  endtask

  // Presents one instruction, waits out any stall, returns just after its accept edge
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic alusrc, input logic regw,
                       input logic memw, input logic m2r, input logic regdst,
                       input logic br, input logic [1:0] op);
    bus.Rs = rs;  bus.Rt = rt;  bus.Rd = rd;  bus.imm16 = imm;
    bus.ALUSource = alusrc;  bus.RegWrite = regw;  bus.MemWrite = memw;
    bus.MemToReg = m2r;  bus.RegDest = regdst;  bus.Branch = br;  bus.ALUControl = op;
    bus.in_valid = 1'b1;
    last_stalls = 0;
    #1;
    while (!bus.in_ready && last_stalls < 8) begin
      @(posedge clk);
      #1;
      last_stalls++;
    end
    if (!bus.in_ready) check_eq("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic iop(input logic [1:0] op, input logic [4:0] rt, input logic [4:0] rs,
                     input logic [15:0] imm);
    issue(rs, rt, 5'd0, imm, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op);
  endtask

  task automatic rop(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs,
                     input logic [4:0] rt);
    issue(rs, rt, rd, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, op);
  endtask

  task automatic sw(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    issue(rs, rt, 5'd0, imm, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OP_ADD);
  endtask

  task automatic lw(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    issue(rs, rt, 5'd0, imm, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, OP_ADD);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;  bus.Rs = '0;  bus.Rt = '0;  bus.Rd = '0;  bus.imm16 = '0;
    bus.ALUSource = 1'b0;  bus.RegWrite = 1'b0;  bus.MemWrite = 1'b0;  bus.MemToReg = 1'b0;
    bus.RegDest = 1'b0;  bus.Branch = 1'b0;  bus.ALUControl = OP_ADD;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check_eq("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    check_eq("rst_flags", nzcv(), 32'h0);
    reset = 1'b1;
    idle(1);

    // 1: single ADDI and its write-back latency
    iop(OP_ADD, 5'd1, 5'd0, 16'd4);
    idle(1);
    check_eq("t1_wb_early", {31'b0, bus.wb_valid}, 32'd0);
    idle(1);
    check_eq("t1_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
    check_eq("t1_wb_addr", {27'b0, bus.wb_addr}, 32'd1);
    check_eq("t1_wb_data", bus.wb_data, 32'd4);
    peek_rs(5'd1);
    check_eq("t1_regRS_bypass", {2'b0, bus.regRS}, 32'd1);
    idle(1);
    check_eq("t1_wb_done", {31'b0, bus.wb_valid}, 32'd0);
    peek_rs(5'd1);
    check_eq("t1_regRS", {2'b0, bus.regRS}, 32'd1);
    idle(2);

    // 2: back-to-back dependent ADDIs
    iop(OP_ADD, 5'd1, 5'd0, 16'd4);
    iop(OP_ADD, 5'd2, 5'd1, 16'd3);
    iop(OP_ADD, 5'd3, 5'd2, 16'd1);
    check_eq("t2_wb_r1", bus.wb_data, 32'd4);
    idle(1);
    check_eq("t2_wb_r2", bus.wb_data, 32'd7);
    idle(1);
    check_eq("t2_wb_r3", bus.wb_data, 32'd8);
    check_eq("t2_wb_addr", {27'b0, bus.wb_addr}, 32'd3);
    idle(3);

    // 3: store, load, dependent add (load-use stall)
    sw(5'd1, 5'd0, 16'd1);
    lw(5'd5, 5'd0, 16'd1);
    check_eq("t3_lw_stalls", last_stalls, 32'd0);
    rop(OP_ADD, 5'd6, 5'd5, 5'd5);
    check_eq("t3_use_stalls", last_stalls, 32'd1);
    check_eq("t3_ready_after", {31'b0, bus.in_ready}, 32'd1);
    check_eq("t3_lw_addr", {27'b0, bus.wb_addr}, 32'd5);
    check_eq("t3_lw_data", bus.wb_data, 32'd4);
    idle(2);
    check_eq("t3_add_addr", {27'b0, bus.wb_addr}, 32'd6);
    check_eq("t3_add_data", bus.wb_data, 32'd8);
    lw(5'd9, 5'd0, 16'd1);
    iop(OP_ADD, 5'd9, 5'd0, 16'd3);
    check_eq("t3_no_stall_imm", last_stalls, 32'd0);
    idle(3);

    // 4: flags; build 0x7FFFFFFF by repeated doubling through the forwarding paths
    iop(OP_ADD, 5'd10, 5'd0, 16'd1);
    for (int i = 0; i < 31; i++) rop(OP_ADD, 5'd10, 5'd10, 5'd10);
    iop(OP_ADD, 5'd10, 5'd10, 16'hFFFF);
    iop(OP_SUB, 5'd11, 5'd10, 16'hFFFF);
    idle(1);
    check_eq("t4_max_pos", bus.wb_data, 32'h7FFF_FFFF);
    check_eq("t4_sub_ovf_flags", nzcv(), 32'b1001);
    idle(1);
    check_eq("t4_sub_ovf_data", bus.wb_data, 32'h8000_0000);
    idle(3);
    check_eq("t4_flags_hold", nzcv(), 32'b1001);
    iop(OP_ADD, 5'd12, 5'd0, 16'd5);
    rop(OP_SUB, 5'd13, 5'd12, 5'd12);
    idle(1);
    check_eq("t4_sub_zero_flags", nzcv(), 32'b0110);
    iop(OP_ADD, 5'd14, 5'd0, 16'h00F0);
    iop(OP_AND, 5'd15, 5'd14, 16'h000F);
    idle(1);
    check_eq("t4_and_flags", nzcv(), 32'b0100);
    idle(1);
    check_eq("t4_and_data", bus.wb_data, 32'd0);
    iop(OP_OR, 5'd16, 5'd14, 16'h000F);
    idle(2);
    check_eq("t4_or_data", bus.wb_data, 32'h0000_00FF);
    check_eq("t4_or_flags", nzcv(), 32'b0000);
    issue(5'd14, 5'd17, 5'd0, 16'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, OP_ADD);
    idle(2);
    check_eq("t4_branch_const", bus.wb_data, 32'h0000_00F0);
    idle(2);

    // 5: register 0 is never written or forwarded
    iop(OP_ADD, 5'd0, 5'd0, 16'd9);
    rop(OP_ADD, 5'd4, 5'd0, 5'd0);
    idle(2);
    check_eq("t5_r4_addr", {27'b0, bus.wb_addr}, 32'd4);
    check_eq("t5_r4_data", bus.wb_data, 32'd0);
    idle(2);
    peek_rs(5'd0);
    check_eq("t5_r0_read", {2'b0, bus.regRS}, 32'd0);
    idle(2);

    // 6: reset with three instructions in flight
    iop(OP_ADD, 5'd8, 5'd0, 16'd55);
    iop(OP_ADD, 5'd7, 5'd0, 16'hFFFF);
    sw(5'd3, 5'd0, 16'd2);
    check_eq("t6_pre_flags", nzcv(), 32'b1000);
    check_eq("t6_pre_wb", {31'b0, bus.wb_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    check_eq("t6_rst_flags", nzcv(), 32'h0);
    check_eq("t6_rst_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    peek_rs(5'd8);
    check_eq("t6_r8_clear", {2'b0, bus.regRS}, 32'd0);
    peek_rs(5'd2);
    check_eq("t6_r2_clear", {2'b0, bus.regRS}, 32'd0);
    lw(5'd9, 5'd0, 16'd1);
    idle(2);
    check_eq("t6_mem_clear", bus.wb_data, 32'd0);
    iop(OP_ADD, 5'd1, 5'd0, 16'd12);
    idle(2);
    check_eq("t6_fresh_valid", {31'b0, bus.wb_valid}, 32'd1);
    check_eq("t6_fresh_data", bus.wb_data, 32'd12);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
